// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index plus hazard-controller shadow entry and FSM state.
package cpu_types_pkg;

  typedef logic [4:0] regbits;

  typedef struct packed {
    logic   valid;
    logic   RegWr;
    logic   MemtoReg;
    logic   memop;
    logic   halt;
    regbits WrDest;
  } hz_entry_t;

  typedef enum logic {RUN, HALTED} hz_state_t;

  // True when a source operand is really read and names the given destination.
  function automatic logic srcMatch(input logic rd, input regbits src, input regbits dest);
    return rd && (src == dest);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: decode/cache status in, latch enables and forwarding shadow out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
);
  logic             ihit, dhit;
  logic [REG_W-1:0] id_rs, id_rt, id_WrDest;
  logic             id_use_rs, id_use_rt, id_RegWr, id_MemtoReg, id_memop, id_halt;
  logic             ex_branch_taken;
  logic             en_ifid, en_idex, en_exmem, en_memwb;
  logic             flush_ifid, flush_idex;
  logic [REG_W-1:0] mem_WrDest, wb_WrDest;
  logic             mem_RegWr, wb_RegWr, mem_MemtoReg;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;

  modport hz (
    input  ihit, dhit, id_rs, id_rt, id_use_rs, id_use_rt, id_RegWr, id_MemtoReg, id_memop,
           id_WrDest, id_halt, ex_branch_taken,
    output en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, mem_WrDest,
           wb_WrDest, mem_RegWr, wb_RegWr, mem_MemtoReg, halted, stall_cycles
  );

  modport tb (
    output ihit, dhit, id_rs, id_rt, id_use_rs, id_use_rt, id_RegWr, id_MemtoReg, id_memop,
           id_WrDest, id_halt, ex_branch_taken,
    input  en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, mem_WrDest,
           wb_WrDest, mem_RegWr, wb_RegWr, mem_MemtoReg, halted, stall_cycles
  );
endinterface

// File: rtl/hz_shadow_stage.sv
// One shadow pipeline entry: advances on enable, loads a bubble when flushed.
module hz_shadow_stage
  import cpu_types_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  input  logic      en,
  input  logic      flush,
  input  hz_entry_t d,
  output hz_entry_t q
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q <= '0;
    end else if (en) begin
      q <= flush ? '0 : d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows EX/MEM/WB destinations and drives latch enables/flushes
// for load-use, data wait, fetch miss, taken branch and halt.
module hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input logic      CLK,
  input logic      RST,
  hazard_ctrl_if.hz hz
);

  hz_entry_t        idEnt, exQ, memQ, wbQ;
  hz_state_t        stateQ, stateD;
  logic [REG_W-1:0] exDest;
  logic [CNT_W-1:0] stallCnt;
  logic             lu, mw, stallCyc;
  logic             enIfid, enIdex, enExmem, enMemwb, flIfid, flIdex;

  always_comb begin
    idEnt          = '0;
    idEnt.valid    = 1'b1;
    idEnt.RegWr    = hz.id_RegWr;
    idEnt.MemtoReg = hz.id_MemtoReg;
    idEnt.memop    = hz.id_memop;
    idEnt.halt     = hz.id_halt;
    idEnt.WrDest   = regbits'(hz.id_WrDest);
  end

  assign exDest = REG_W'(exQ.WrDest);
  assign lu = exQ.valid && exQ.MemtoReg && exQ.RegWr && (exDest != '0) &&
              (srcMatch(hz.id_use_rs, regbits'(hz.id_rs), exQ.WrDest) ||
               srcMatch(hz.id_use_rt, regbits'(hz.id_rt), exQ.WrDest));
  assign mw = memQ.valid && memQ.memop && !hz.dhit;

  always_comb begin
    stateD  = stateQ;
    enIfid  = 1'b0;
    enIdex  = 1'b0;
    enExmem = 1'b0;
    enMemwb = 1'b0;
    flIfid  = 1'b0;
    flIdex  = 1'b0;
    if (stateQ == RUN) begin
      if (wbQ.valid && wbQ.halt) stateD = HALTED;
      if (mw) begin
        // everything freezes; a pending branch is re-seen next cycle from the frozen EX
      end else if (hz.ex_branch_taken) begin
        {enIfid, enIdex, enExmem, enMemwb, flIfid, flIdex} = 6'b111111;
      end else if (lu) begin
        {enIfid, enIdex, enExmem, enMemwb, flIfid, flIdex} = 6'b011101;
      end else if (!hz.ihit) begin
        {enIfid, enIdex, enExmem, enMemwb, flIfid, flIdex} = 6'b111110;
      end else begin
        {enIfid, enIdex, enExmem, enMemwb, flIfid, flIdex} = 6'b111100;
      end
    end
    if (RST) begin
      {enIfid, enIdex, enExmem, enMemwb, flIfid, flIdex} = 6'b000000;
    end
  end

  assign stallCyc = (stateQ == RUN) && (!enIdex || flIdex);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stateQ   <= RUN;
      stallCnt <= '0;
    end else begin
      stateQ <= stateD;
      if (stallCyc && (stallCnt != '1)) stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  hz_shadow_stage exStage (
    .CLK  (CLK),
    .RST  (RST),
    .en   (enIdex),
    .flush(flIdex),
    .d    (idEnt),
    .q    (exQ)
  );

  hz_shadow_stage memStage (
    .CLK  (CLK),
    .RST  (RST),
    .en   (enExmem),
    .flush(1'b0),
    .d    (exQ),
    .q    (memQ)
  );

  hz_shadow_stage wbStage (
    .CLK  (CLK),
    .RST  (RST),
    .en   (enMemwb),
    .flush(1'b0),
    .d    (memQ),
    .q    (wbQ)
  );

  logic unusedWbBits;
  assign unusedWbBits = ^{wbQ.MemtoReg, wbQ.memop};

  assign hz.en_ifid      = enIfid;
  assign hz.en_idex      = enIdex;
  assign hz.en_exmem     = enExmem;
  assign hz.en_memwb     = enMemwb;
  assign hz.flush_ifid   = flIfid;
  assign hz.flush_idex   = flIdex;
  assign hz.mem_WrDest   = REG_W'(memQ.WrDest);
  assign hz.wb_WrDest    = REG_W'(wbQ.WrDest);
  assign hz.mem_RegWr    = memQ.valid && memQ.RegWr;
  assign hz.wb_RegWr     = wbQ.valid && wbQ.RegWr;
  assign hz.mem_MemtoReg = memQ.valid && memQ.MemtoReg;
  assign hz.halted       = (stateQ == HALTED);
  assign hz.stall_cycles = stallCnt;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS datapath.
- Keeps a shadow copy of the in-flight destination state (EX, MEM, WB) and exports the mem/wb write-destination signals that the forwarding unit consumes.
- Resolves the hazards forwarding cannot cover: load-use, data-memory wait, instruction-fetch miss, taken-branch squash and halt.
- Drives the enable and flush inputs of the four pipeline latches.

Parameters:
- CNT_W, 32, width of the saturating stall-cycle counter.
- REG_W, 5, register-index width; equals the width of regbits in cpu_types_pkg.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- ihit  in  1  instruction fetch completed this cycle.
- dhit  in  1  data access completed this cycle.
- id_rs, id_rt  in  REG_W  source registers of the instruction in decode.
- id_use_rs, id_use_rt  in  1  decode instruction actually reads rs / rt.
- id_RegWr  in  1  decode instruction writes a register.
- id_MemtoReg  in  1  decode instruction is a load.
- id_memop  in  1  decode instruction accesses data memory (load or store).
- id_WrDest  in  REG_W  destination register of the decode instruction.
- id_halt  in  1  decode instruction is HALT.
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- en_ifid, en_idex, en_exmem, en_memwb  out  1  latch enables.
- flush_ifid, flush_idex  out  1  load a bubble into the latch (only meaningful while its enable=1).
- mem_WrDest, wb_WrDest  out  REG_W  shadow destinations, fed to the forwarding unit.
- mem_RegWr, wb_RegWr, mem_MemtoReg  out  1  shadow controls, fed to the forwarding unit.
- halted  out  1  processor halted.
- stall_cycles  out  CNT_W  count of cycles in which en_idex=0 or flush_idex=1.

Behaviour:
- Shadow pipeline:
  - Registered entries EX, MEM, WB, each holding {valid, RegWr, MemtoReg, memop, halt, WrDest}.
  - An entry advances only when the enable of the latch feeding it is 1.
  - A flushed or bubbled entry becomes valid=0.
  - Exported RegWr/MemtoReg outputs are gated with valid.
- Hazard conditions:
  - lu (load-use): EX.valid & EX.MemtoReg & EX.RegWr & EX.WrDest!=0 & ((id_use_rs & id_rs==EX.WrDest) | (id_use_rt & id_rt==EX.WrDest)).
  - mw (memory wait): MEM.valid & MEM.memop & !dhit.
- FSM states: RUN, HALTED.
  - RUN -> HALTED when WB.valid & WB.halt.
  - HALTED is left only by reset.
- Priority in RUN; the first matching row applies:
  1. mw: all enables 0, no flush; every stage freezes.
  2. ex_branch_taken: all enables 1, flush_ifid=1, flush_idex=1.
  3. lu: en_ifid=0, en_idex=1 with flush_idex=1 (one bubble), en_exmem=en_memwb=1.
  4. !ihit: en_ifid=1, flush_ifid=1 (bubble into decode), all others 1.
  5. Otherwise: all enables 1, no flush.
- Boundary rules:
  - lu with WrDest=0 never stalls.
  - lu and !ihit together: lu wins; IF/ID holds its contents.
  - Branch and mw together: mw wins; the branch is re-evaluated next cycle because EX is frozen.
  - A bubble clears lu in the next cycle, so a load-use stall lasts exactly 1 cycle.
- HALTED: all enables 0, flush 0, halted=1, shadow entries frozen.
- Reset, asynchronous and active-high:
  - State RUN; all shadow entries invalid; stall_cycles=0; halted=0.
  - While RST=1, all enables and flushes are 0.
- stall_cycles: increments by 1 per qualifying cycle in RUN and saturates at all-ones.
- Latency: all control outputs are combinational from the registered shadow state plus the current inputs. Shadow entries and stall_cycles update on the CLK edge.

Decomposition:
- cpu_types_pkg gains:
  - hz_entry_t, a struct holding the shadow fields listed above.
  - hz_state_t, an enum {RUN, HALTED}.
  - regbits, reused from the existing package.
- hazard_ctrl_if follows the existing interface style with modports hz and tb.
- Sub-module hz_shadow_stage: one shadow entry register with enable/flush. Instantiated three times.

Test Plan:
- lw $3 in EX, add reading $3 in ID, ihit=dhit=1 -> exactly 1 cycle of en_ifid=0, flush_idex=1; stall_cycles 0->1; next cycle all enables 1.
- lw $0 in EX, ID reads $0 -> no stall, all enables 1.
- sw in MEM with dhit=0 for 3 cycles -> all enables 0 for 3 cycles, shadow outputs constant; on dhit=1 normal advance resumes.
- ex_branch_taken=1 with lu true in the same cycle -> flush_ifid=1, flush_idex=1, en_ifid=1 (branch wins).
- HALT issued, ihit=dhit=1 -> halted=1 four cycles later, enables 0; RST asserted mid-halt -> halted=0 and stall_cycles=0 immediately, without waiting for a clock edge.
- Preload stall_cycles near all-ones (CNT_W=4, 20 lu events) -> counter saturates at 15.
